tdc_meas_ctrl: RTL and testbench

- Synchronous controller on both sides of the three-step ring-oscillator TDC core.
- Upstream: drives the level `start` enable into the core.
- Downstream: consumes the core's asynchronous `stop` event and its 6-bit code (coarse [5:4], mid [3:2], fine [1:0]). Captures the code after a settle window and repeats for 2^LOG2_AVG measurements.
- Returns average, min and max of the batch to the system over a valid/ready handshake.

---
 rtl/tdc_meas_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_tdc_meas_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_meas_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tdc_meas_ctrl
//  Purpose  : Measurement sequencer around a three-step ring-oscillator TDC.
//             Enables the core (tdc_start), waits for the asynchronous stop
//             event, lets the latch/step cascade settle, captures the code and
//             repeats for 2^LOG2_AVG measurements. The batch average, minimum,
//             maximum and a sticky timeout flag are returned over valid/ready.
//  Ports    : clk, reset (async, active-high)
//             arm                     - one-cycle batch request (IDLE only)
//             tdc_stop, tdc_code      - asynchronous stop level / TDC result
//             tdc_start               - core enable, high in RUN and SETTLE
//             busy                    - high whenever not IDLE
//             res_valid, res_ready    - result handshake
//             res_avg/min/max/timeout - batch result, held while valid
//  Revision : 1.0 - initial release
// ============================================================================
module tdc_meas_ctrl #(
    parameter int CODE_W      = 6,
    parameter int SETTLE_CYC  = 8,
    parameter int RECOVER_CYC = 4,
    parameter int LOG2_AVG    = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              tdc_stop,
    input  logic [CODE_W-1:0] tdc_code,
    output logic              tdc_start,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CODE_W-1:0] res_avg,
    output logic [CODE_W-1:0] res_min,
    output logic [CODE_W-1:0] res_max,
    output logic              res_timeout
);

    localparam int ACC_W = CODE_W + LOG2_AVG;
    localparam int CNT_W = LOG2_AVG + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int REC_W = $clog2(RECOVER_CYC + 1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_run     = 3'd1;
    localparam logic [2:0] c_st_settle  = 3'd2;
    localparam logic [2:0] c_st_capture = 3'd3;
    localparam logic [2:0] c_st_recover = 3'd4;
    localparam logic [2:0] c_st_out     = 3'd5;

    // Terminal counts: each counter starts at 0 in the first cycle of its state.
    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [SET_W-1:0] c_set_last = SET_W'(SETTLE_CYC - 1);
    localparam logic [REC_W-1:0] c_rec_last = REC_W'(RECOVER_CYC - 1);
    localparam logic [CNT_W-1:0] c_batch    = CNT_W'(1 << LOG2_AVG);

    logic [2:0]        r_state;
    logic              r_sync1, r_sync2, r_sync_d;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [CODE_W-1:0] r_min, r_max;
    logic              r_tmo_flag;
    logic              r_meas_tmo;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [SET_W-1:0]  r_set_cnt;
    logic [REC_W-1:0]  r_rec_cnt;
    logic [CODE_W-1:0] r_res_avg, r_res_min, r_res_max;
    logic              r_res_tmo;

    logic              w_stop_rise;
    logic [CODE_W-1:0] w_code;

    // Two-flop synchronizer plus edge-detect flop on the asynchronous stop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync1  <= tdc_stop;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    // A stop that is already high when RUN begins produces no edge here.
    assign w_stop_rise = r_sync2 & ~r_sync_d;

    // A timed-out measurement contributes the full-scale code.
    assign w_code = r_meas_tmo ? {CODE_W{1'b1}} : tdc_code;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_min      <= '1;
            r_max      <= '0;
            r_tmo_flag <= 1'b0;
            r_meas_tmo <= 1'b0;
            r_tmo_cnt  <= '0;
            r_set_cnt  <= '0;
            r_rec_cnt  <= '0;
            r_res_avg  <= '0;
            r_res_min  <= '0;
            r_res_max  <= '0;
            r_res_tmo  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (arm) begin
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_min      <= '1;
                        r_max      <= '0;
                        r_tmo_flag <= 1'b0;
                        r_meas_tmo <= 1'b0;
                        r_tmo_cnt  <= '0;
                        r_state    <= c_st_run;
                    end
                end
                c_st_run: begin
                    // Stop edge has priority over an expiring timeout.
                    if (w_stop_rise) begin
                        r_set_cnt <= '0;
                        r_state   <= c_st_settle;
                    end else if (r_tmo_cnt == c_tmo_last) begin
                        r_meas_tmo <= 1'b1;
                        r_tmo_flag <= 1'b1;
                        r_state    <= c_st_capture;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                c_st_settle: begin
                    if (r_set_cnt == c_set_last) begin
                        r_state <= c_st_capture;
                    end else begin
                        r_set_cnt <= r_set_cnt + SET_W'(1);
                    end
                end
                c_st_capture: begin
                    r_acc     <= r_acc + ACC_W'(w_code);
                    r_min     <= (w_code < r_min) ? w_code : r_min;
                    r_max     <= (w_code > r_max) ? w_code : r_max;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    r_rec_cnt <= '0;
                    r_state   <= c_st_recover;
                end
                c_st_recover: begin
                    // Counter saturates at its terminal value; exit also waits
                    // for the synchronized stop to fall so the next RUN can see
                    // a fresh rising edge.
                    if (r_rec_cnt != c_rec_last) begin
                        r_rec_cnt <= r_rec_cnt + REC_W'(1);
                    end else if (!r_sync2) begin
                        if (r_cnt == c_batch) begin
                            r_res_avg <= r_acc[LOG2_AVG +: CODE_W];
                            r_res_min <= r_min;
                            r_res_max <= r_max;
                            r_res_tmo <= r_tmo_flag;
                            r_state   <= c_st_out;
                        end else begin
                            r_tmo_cnt  <= '0;
                            r_meas_tmo <= 1'b0;
                            r_state    <= c_st_run;
                        end
                    end
                end
                c_st_out: begin
                    if (res_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign tdc_start   = (r_state == c_st_run) || (r_state == c_st_settle);
    assign busy        = (r_state != c_st_idle);
    assign res_valid   = (r_state == c_st_out);
    assign res_avg     = r_res_avg;
    assign res_min     = r_res_min;
    assign res_max     = r_res_max;
    assign res_timeout = r_res_tmo;

endmodule
`default_nettype wire

// File: tb/tb_tdc_meas_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdc_meas_ctrl
//  Purpose  : Self-checking bench for tdc_meas_ctrl. Expected batch results
//             are queued when a batch is launched and compared when the DUT
//             presents them on the result handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tdc_meas_ctrl;

    localparam int RECOVER_CYC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       arm;
    logic       tdc_stop;
    logic [5:0] tdc_code;
    logic       tdc_start;
    logic       busy;
    logic       res_valid;
    logic       res_ready;
    logic [5:0] res_avg, res_min, res_max;
    logic       res_timeout;

    tdc_meas_ctrl #(
        .CODE_W(6), .SETTLE_CYC(8), .RECOVER_CYC(RECOVER_CYC),
        .LOG2_AVG(2), .TIMEOUT_CYC(255)
    ) u_dut (
        .clk(clk), .reset(reset), .arm(arm),
        .tdc_stop(tdc_stop), .tdc_code(tdc_code),
        .tdc_start(tdc_start), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_avg(res_avg), .res_min(res_min), .res_max(res_max),
        .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] avg;
        logic [5:0] mn;
        logic [5:0] mx;
        logic       tmo;
    } res_t;

    res_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // tdc_start pulse counter and minimum low gap between pulses.
    int   pulse_cnt = 0;
    int   cur_low   = 0;
    int   min_gap   = 1000;
    logic had_pulse = 1'b0;
    logic prev_st   = 1'b0;
    always @(negedge clk) begin
        if (tdc_start && !prev_st) begin
            pulse_cnt++;
            if (had_pulse && cur_low < min_gap) min_gap = cur_low;
            had_pulse = 1'b1;
        end
        if (!tdc_start) cur_low++;
        else cur_low = 0;
        prev_st = tdc_start;
    end

    // Launch a batch: model the expected result from the effective codes.
    task automatic start_batch(input logic [5:0] c0, input logic [5:0] c1,
                               input logic [5:0] c2, input logic [5:0] c3,
                               input logic tmo);
        res_t       e;
        logic [5:0] c [4];
        int         sum;
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        sum = 0; e.mn = 6'h3f; e.mx = 6'h00;
        for (int i = 0; i < 4; i++) begin
            sum += int'(c[i]);
            if (c[i] < e.mn) e.mn = c[i];
            if (c[i] > e.mx) e.mx = c[i];
        end
        e.avg = 6'(sum / 4);
        e.tmo = tmo;
        sb.push_back(e);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    // One measurement: wait for tdc_start, apply stop after dly cycles,
    // optionally change the code chg_at cycles after stop, optionally keep
    // stop high for hold cycles after capture.
    task automatic meas(input logic [5:0] code, input int dly, input logic tmo,
                        input int chg_at, input logic [5:0] code2, input int hold);
        int   k;
        logic low_ok;
        k = 0;
        while (!tdc_start && k < 400) begin @(negedge clk); k++; end
        if (!tdc_start) chk("start_rise_wait", 32'd0, 32'd1);
        tdc_code = code;
        if (tmo) begin
            k = 0;
            while (tdc_start && k < 400) begin @(negedge clk); k++; end
            chk("tmo_run_len", k, 255);
            return;
        end
        repeat (dly) @(negedge clk);
        tdc_stop = 1'b1;
        k = 0;
        while (k < 400) begin
            @(negedge clk);
            k++;
            if (k == chg_at) tdc_code = code2;
            if (!tdc_start && k >= chg_at) break;
        end
        if (k >= 400) chk("start_fall_wait", 32'd0, 32'd1);
        if (hold > 0) begin
            low_ok = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (tdc_start) low_ok = 1'b0;
            end
            chk("hold_start_low", low_ok, 1);
            tdc_stop = 1'b0;
            k = 0;
            while (!tdc_start && k < 20) begin @(negedge clk); k++; end
            chk("rerun_latency", k, 3);
        end else begin
            tdc_stop = 1'b0;
        end
    endtask

    // Wait for a result, optionally backpressure it, compare, then accept.
    task automatic collect(input int bp, input logic poke_arm);
        res_t       e;
        int         k;
        logic       stable;
        logic [5:0] a, mn, mx;
        logic       t;
        k = 0;
        while (!res_valid && k < 2000) begin @(negedge clk); k++; end
        chk("res_valid_wait", res_valid, 1);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        a = res_avg; mn = res_min; mx = res_max; t = res_timeout;
        stable = 1'b1;
        for (int i = 0; i < bp; i++) begin
            arm = (poke_arm && i == 10);
            @(negedge clk);
            if (!res_valid || !busy || res_avg != a || res_min != mn ||
                res_max != mx || res_timeout != t) stable = 1'b0;
        end
        arm = 1'b0;
        if (bp > 0) chk("bp_stable", stable, 1);
        chk("res_avg", res_avg, e.avg);
        chk("res_min", res_min, e.mn);
        chk("res_max", res_max, e.mx);
        chk("res_timeout", res_timeout, e.tmo);
        res_ready = 1'b1;
        arm = poke_arm;
        @(negedge clk);
        res_ready = 1'b0;
        arm = 1'b0;
        chk("valid_drop", res_valid, 0);
        chk("idle_after_xfer", busy, 0);
        repeat (3) @(negedge clk);
        chk("no_rearm", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int p0, k;
        reset = 1'b1; arm = 1'b0; tdc_stop = 1'b0; tdc_code = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tdc_start", tdc_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_avg", res_avg, 0);
        chk("rst_res_max", res_max, 0);
        reset = 1'b0;
        @(negedge clk);

        // Basic batch, pulse count and recovery gap.
        p0 = pulse_cnt; had_pulse = 1'b0; min_gap = 1000;
        start_batch(10, 12, 14, 16, 1'b0);
        meas(10, 20, 0, 0, 0, 0);
        meas(12, 20, 0, 0, 0, 0);
        meas(14, 20, 0, 0, 0, 0);
        meas(16, 20, 0, 0, 0, 0);
        collect(0, 1'b0);
        chk("start_pulses", pulse_cnt - p0, 4);
        chk("recover_gap_ok", (min_gap >= RECOVER_CYC), 1);

        // Capture window: late-settling change is seen, post-capture change is not.
        start_batch(9, 5, 7, 7, 1'b0);
        meas(5, 20, 0, 5, 9, 0);
        meas(5, 20, 0, 22, 9, 0);
        meas(7, 20, 0, 0, 0, 0);
        meas(7, 20, 0, 0, 0, 0);
        collect(0, 1'b0);

        // Timeout on the second measurement.
        start_batch(8, 63, 8, 8, 1'b1);
        meas(8, 20, 0, 0, 0, 0);
        meas(8, 0, 1, 0, 0, 0);
        meas(8, 20, 0, 0, 0, 0);
        meas(8, 20, 0, 0, 0, 0);
        collect(0, 1'b0);

        // Stop held through RECOVER, then backpressure with arm poked in OUT.
        start_batch(3, 40, 20, 33, 1'b0);
        meas(3, 15, 0, 0, 0, 0);
        meas(40, 15, 0, 0, 0, 30);
        meas(20, 15, 0, 0, 0, 0);
        meas(33, 15, 0, 0, 0, 0);
        collect(50, 1'b1);

        // Reset in the third RUN of a batch, then a clean batch.
        arm = 1'b1; @(negedge clk); arm = 1'b0;
        meas(50, 20, 0, 0, 0, 0);
        meas(60, 20, 0, 0, 0, 0);
        k = 0;
        while (!tdc_start && k < 100) begin @(negedge clk); k++; end
        chk("pre_reset_run", tdc_start, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_start", tdc_start, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_valid", res_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_avg", res_avg, 0);
        start_batch(1, 1, 1, 1, 1'b0);
        meas(1, 20, 0, 0, 0, 0);
        meas(1, 20, 0, 0, 0, 0);
        meas(1, 20, 0, 0, 0, 0);
        meas(1, 20, 0, 0, 0, 0);
        collect(0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
